instruction_fetch: RTL

//  Front-end fetch unit; consumes the branch unit's resolved target (iPCBR) on a redirect.

---
 rtl/instruction_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: owns the PC, issues req/gnt reads, hands words to decode.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module instruction_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            iCLK,
    input  logic            iRST,
    output logic            oIMEM_REQ,
    output logic [PC_W-1:0] oIMEM_ADDR,
    input  logic            iIMEM_GNT,
    input  logic            iIMEM_RVALID,
    input  logic [31:0]     iIMEM_RDATA,
    output logic [31:0]     oIR,
    output logic [PC_W-1:0] oPC,
    output logic            oIR_VALID,
    input  logic            iIR_READY,
    input  logic            iREDIRECT,
    input  logic [PC_W-1:0] iPCBR
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     oFETCH_CNT,
    output logic [15:0]     oDROP_CNT
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            drop_reg, drop_next;
    logic [31:0]     ir_reg, ir_next;
    logic [PC_W-1:0] ir_pc_reg, ir_pc_next;
    logic            req_reg, req_next;
    logic            valid_reg, valid_next;
    logic [PC_W-1:0] target;

    assign target = {iPCBR[PC_W-1:2], 2'b00};

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;
        ir_next    = ir_reg;
        ir_pc_next = ir_pc_reg;
        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (iIMEM_GNT) begin
                    state_next = WAIT;
                    drop_next  = iREDIRECT;
                end
            end
            WAIT: begin
                if (iIMEM_RVALID) begin
                    // A redirect in the response cycle makes the word stale just like a pending drop.
                    if (drop_reg || iREDIRECT) begin
                        state_next = REQ;
                        drop_next  = 1'b0;
                    end else begin
                        state_next = HOLD;
                        ir_next    = iIMEM_RDATA;
                        ir_pc_next = pc_reg;
                        pc_next    = pc_reg + PC_W'(4);
                    end
                end else if (iREDIRECT) begin
                    drop_next = 1'b1;
                end
            end
            HOLD: begin
                if (iIR_READY || iREDIRECT) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        // Redirect always wins the PC, even over a same-cycle delivery handshake.
        if (iREDIRECT) begin
            pc_next = target;
        end
        req_next   = (state_next == REQ);
        valid_next = (state_next == HOLD);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            drop_reg  <= 1'b0;
            ir_reg    <= '0;
            ir_pc_reg <= '0;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            drop_reg  <= drop_next;
            ir_reg    <= ir_next;
            ir_pc_reg <= ir_pc_next;
            req_reg   <= req_next;
            valid_reg <= valid_next;
        end
    end

    assign oIMEM_REQ  = req_reg;
    assign oIMEM_ADDR = {pc_reg[PC_W-1:2], 2'b00};
    assign oIR        = ir_reg;
    assign oPC        = ir_pc_reg;
    assign oIR_VALID  = valid_reg;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_reg;
    logic [15:0] drop_cnt_reg;

    // Drop count covers only responses discarded by an earlier redirect (drop flag set).
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fetch_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            if (state_reg == HOLD && iIR_READY) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (state_reg == WAIT && iIMEM_RVALID && drop_reg) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign oFETCH_CNT = fetch_cnt_reg;
    assign oDROP_CNT  = drop_cnt_reg;
`else
    // Counters are not built in this configuration.
`endif

endmodule
